// File: rtl/fix_parser.sv
// Streaming FIX parser: splits a byte stream into tag=value fields, stores complete
// messages in a small message store, verifies the trailer checksum, and serves tag lookups.
module fix_parser #(
    parameter int MAX_MSGS   = 4,
    parameter int MAX_FIELDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   data_i,
    input  logic [31:0]  find_tag_i,
    input  logic [9:0]   message_num_i,
    input  logic         read_message_i,
    output logic [255:0] output_value_o,
    output logic         output_value_valid_o,
    output logic         start_of_header_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [8:0]   checksum_o
);
    localparam int MW  = (MAX_MSGS > 1) ? $clog2(MAX_MSGS) : 1;
    localparam int CW  = $clog2(MAX_MSGS + 1);
    localparam int FW  = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
    localparam int FCW = $clog2(MAX_FIELDS + 1);

    localparam logic [7:0]  SOH     = 8'h01;
    localparam logic [7:0]  EQ      = 8'h3D;
    localparam logic [31:0] TAG_BEG = 32'h0000_0038;
    localparam logic [31:0] TAG_CK  = 32'h0000_3130;

    typedef struct packed {
        logic [31:0]  tag;
        logic [255:0] val;
    } field_t;

    typedef enum logic [1:0] {P_IDLE, P_TAG, P_VALUE} p_state_t;
    typedef enum logic {LK_IDLE, LK_SCAN} lk_state_t;

    field_t         mem      [MAX_MSGS][MAX_FIELDS];
    logic [FCW-1:0] nfld_mem [MAX_MSGS];

    p_state_t       state;
    logic [31:0]    tag_r;
    logic [255:0]   val_r;
    logic           msg_open;
    logic           drop;
    logic [FCW-1:0] fld_cnt;
    logic [7:0]     csum_sum;
    logic [7:0]     csum_base;
    logic [CW-1:0]  count;

    logic           is_soh, is_eq;
    logic           fld_end, fld_wr, commit;
    logic [MW-1:0]  wr_idx;
    logic           dig_ok, mismatch;
    logic [9:0]     dig_val;

    assign is_soh  = (data_i == SOH);
    assign is_eq   = (data_i == EQ);
    assign fld_end = (state == P_VALUE) && is_soh && msg_open;
    assign fld_wr  = fld_end && !drop && (fld_cnt < FCW'(MAX_FIELDS));
    assign commit  = fld_end && (tag_r == TAG_CK);
    assign wr_idx  = MW'(count);

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(MAX_MSGS));

    // Digits sit in the low nibble of each ASCII byte once the range check passes.
    always_comb begin
        dig_ok = (val_r[255:24] == '0);
        for (int i = 0; i < 3; i++)
            if (val_r[8*i +: 8] < 8'h30 || val_r[8*i +: 8] > 8'h39) dig_ok = 1'b0;
        dig_val  = 10'(val_r[19:16]) * 10'd100 + 10'(val_r[11:8]) * 10'd10 + 10'(val_r[3:0]);
        mismatch = !(dig_ok && (dig_val == {2'b00, csum_base}));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= P_IDLE;
            tag_r             <= '0;
            val_r             <= '0;
            msg_open          <= 1'b0;
            drop              <= 1'b0;
            fld_cnt           <= '0;
            csum_sum          <= '0;
            csum_base         <= '0;
            count             <= '0;
            checksum_o        <= '0;
            start_of_header_o <= 1'b0;
        end else begin
            start_of_header_o <= 1'b0;
            // csum_base trails csum_sum by the current field, so at the trailer it
            // holds the sum through the SOH that precedes tag "10".
            if (msg_open) csum_sum <= csum_sum + data_i;
            if (msg_open && is_soh) csum_base <= csum_sum + data_i;
            case (state)
                P_IDLE: if (is_soh) state <= P_TAG;
                P_TAG: begin
                    if (is_eq) begin
                        state <= P_VALUE;
                        if (tag_r == TAG_BEG && !msg_open) begin
                            msg_open          <= 1'b1;
                            drop              <= full_o;
                            fld_cnt           <= '0;
                            csum_sum          <= 8'h38 + EQ;
                            start_of_header_o <= 1'b1;
                        end
                    end else if (!(is_soh && tag_r == '0)) begin
                        tag_r <= {tag_r[23:0], data_i};
                    end
                end
                P_VALUE: begin
                    if (is_soh) begin
                        tag_r <= '0;
                        val_r <= '0;
                        state <= P_TAG;
                        if (fld_end && fld_cnt < FCW'(MAX_FIELDS)) fld_cnt <= fld_cnt + 1'b1;
                        if (commit) begin
                            checksum_o <= {mismatch, csum_base};
                            msg_open   <= 1'b0;
                            if (!drop) count <= count + 1'b1;
                        end
                    end else begin
                        val_r <= {val_r[247:0], data_i};
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end

    // Store contents need no reset: only slots below count are ever searched.
    always_ff @(posedge clk) begin
        if (fld_wr) mem[wr_idx][FW'(fld_cnt)] <= {tag_r, val_r};
        if (commit && !drop) nfld_mem[wr_idx] <= fld_cnt + FCW'(fld_wr);
    end

    lk_state_t     lk_state;
    logic [MW-1:0] lk_msg;
    logic [31:0]   lk_tag;
    logic [FW-1:0] lk_idx;
    logic          lk_hit;

    assign lk_hit = (FCW'(lk_idx) < nfld_mem[lk_msg]) && (mem[lk_msg][lk_idx].tag == lk_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_state             <= LK_IDLE;
            lk_msg               <= '0;
            lk_tag               <= '0;
            lk_idx               <= '0;
            output_value_o       <= '0;
            output_value_valid_o <= 1'b0;
        end else begin
            output_value_valid_o <= 1'b0;
            case (lk_state)
                LK_IDLE: begin
                    if (read_message_i && message_num_i < 10'(count)) begin
                        lk_msg   <= MW'(message_num_i);
                        lk_tag   <= find_tag_i;
                        lk_idx   <= '0;
                        lk_state <= LK_SCAN;
                    end
                end
                LK_SCAN: begin
                    if (lk_hit) begin
                        output_value_o       <= mem[lk_msg][lk_idx].val;
                        output_value_valid_o <= 1'b1;
                        lk_state             <= LK_IDLE;
                    end else if (lk_idx == FW'(MAX_FIELDS - 1)) begin
                        lk_state <= LK_IDLE;
                    end else begin
                        lk_idx <= lk_idx + 1'b1;
                    end
                end
                default: lk_state <= LK_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_parser.sv
// Directed bench for fix_parser: streams FIX messages, models checksum/count, and
// scoreboards lookup results against a queue of expected values.
module tb_fix_parser;
    localparam int MAX_MSGS   = 4;
    localparam int MAX_FIELDS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   data_i = 8'h01;
    logic [31:0]  find_tag_i = '0;
    logic [9:0]   message_num_i = '0;
    logic         read_message_i = 1'b0;
    logic [255:0] output_value_o;
    logic         output_value_valid_o;
    logic         start_of_header_o;
    logic         empty_o;
    logic         full_o;
    logic [8:0]   checksum_o;

    fix_parser #(.MAX_MSGS(MAX_MSGS), .MAX_FIELDS(MAX_FIELDS)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .find_tag_i(find_tag_i),
        .message_num_i(message_num_i), .read_message_i(read_message_i),
        .output_value_o(output_value_o), .output_value_valid_o(output_value_valid_o),
        .start_of_header_o(start_of_header_o), .empty_o(empty_o), .full_o(full_o),
        .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, sof_cnt = 0, pulse_cnt = 0, mcount = 0;
    logic [255:0] exp_q[$];
    logic [255:0] last_val = '0;
    logic [23:0]  last_ck = '0;
    string PFX = "|8=FIX.4.2|9=178|35=8|49=PHLX|52=20071123-05:30:00.000|11=ATOMNOCCC9990900|10=";

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] s2v(string s);
        logic [255:0] v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[247:0], 8'(s[i])};
        return v;
    endfunction

    always @(negedge clk) begin
        if (start_of_header_o) sof_cnt++;
        if (output_value_valid_o) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
            else check("lookup_value", output_value_o, exp_q.pop_front());
        end
    end

    task automatic send_byte(logic [7:0] b);
        data_i = b;
        @(posedge clk); #1;
    endtask

    // '|' stands for SOH; pfx ends in "10=" and the trailer value bytes are passed separately.
    task automatic send_msg(string pfx, bit auto_ck, logic [23:0] ck_in);
        int s = 0, sof0 = sof_cnt, v = 0;
        bit ok = 1'b1;
        logic [7:0] b;
        logic [23:0] ck = ck_in;
        for (int i = 0; i < pfx.len(); i++) begin
            b = (pfx[i] == "|") ? 8'h01 : 8'(pfx[i]);
            send_byte(b);
            if (i >= 1 && i <= pfx.len() - 4) s += int'(b);
        end
        s = s % 256;
        if (auto_ck) ck = {8'(48 + s / 100), 8'(48 + (s / 10) % 10), 8'(48 + s % 10)};
        for (int i = 2; i >= 0; i--) begin
            b = ck[8*i +: 8];
            send_byte(b);
            if (b < 8'h30 || b > 8'h39) ok = 1'b0;
            v = v * 10 + int'(b) - 48;
        end
        check("empty_before_commit", empty_o, (mcount == 0));
        send_byte(8'h01);
        if (mcount < MAX_MSGS) mcount++;
        last_ck = ck;
        check("checksum", checksum_o, {!(ok && v == s), 8'(s)});
        check("empty_after_commit", empty_o, (mcount == 0));
        check("full_after_commit", full_o, (mcount == MAX_MSGS));
        check("sof_pulses", sof_cnt - sof0, 1);
    endtask

    // k is the expected matching field index, or -1 for no pulse.
    task automatic lookup(int msg, logic [31:0] tag, int k, logic [255:0] ev);
        int seen = 0;
        if (k >= 0) begin
            exp_q.push_back(ev);
            last_val = ev;
        end
        message_num_i  = 10'(msg);
        find_tag_i     = tag;
        read_message_i = 1'b1;
        @(posedge clk); #1;
        read_message_i = 1'b0;
        for (int i = 1; i <= MAX_FIELDS + 2; i++) begin
            @(posedge clk); #1;
            if (output_value_valid_o && seen == 0) seen = i;
        end
        check("lookup_latency", seen, (k >= 0) ? k + 1 : 0);
        check("lookup_pending", exp_q.size(), 0);
        check("lookup_hold", output_value_o, last_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", output_value_o, 0);
        check("rst_valid", output_value_valid_o, 0);
        check("rst_sof", start_of_header_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_checksum", checksum_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        send_msg(PFX, 1'b0, 24'h313238);
        lookup(0, 32'h3130, 6, 256'h313238);
        lookup(0, 32'h39,   1, 256'h313738);
        lookup(0, 32'h3131, 5, s2v("ATOMNOCCC9990900"));

        send_msg(PFX, 1'b0, 24'h876545);
        check("bad_ck_flag", checksum_o[8], 1);
        lookup(1, 32'h3130, 6, 256'h876545);
        lookup(0, 32'h3939, -1, '0);
        lookup(5, 32'h39,   -1, '0);

        for (int m = 0; m < 3; m++) send_msg(PFX, 1'b1, '0);
        check("full_kept", full_o, 1);
        lookup(4, 32'h39, -1, '0);
        lookup(3, 32'h39, 1, 256'h313738);

        for (int i = 0; i < 15; i++) begin
            string part = "|8=FIX.4.2|9=17";
            send_byte((part[i] == "|") ? 8'h01 : 8'(part[i]));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_empty", empty_o, 1);
        check("midrst_full", full_o, 0);
        check("midrst_checksum", checksum_o, 0);
        rst = 1'b1;
        mcount = 0;
        last_val = '0;
        data_i = 8'h01;
        @(posedge clk); #1;
        send_msg("|8=FIX.4.2|9=42|35=8|10=", 1'b1, '0);
        lookup(0, 32'h39, 1, 256'h3432);
        lookup(1, 32'h39, -1, '0);

        p0 = pulse_cnt;
        exp_q.push_back({232'b0, last_ck});
        last_val = {232'b0, last_ck};
        message_num_i = 10'd0;
        find_tag_i = 32'h3130;
        read_message_i = 1'b1;
        @(posedge clk); #1;
        read_message_i = 1'b0;
        @(posedge clk); #1;
        find_tag_i = 32'h39;
        read_message_i = 1'b1;
        @(posedge clk); #1;
        read_message_i = 1'b0;
        repeat (MAX_FIELDS + 2) @(posedge clk);
        #1;
        check("busy_strobe_pulses", pulse_cnt - p0, 1);
        check("busy_strobe_pending", exp_q.size(), 0);
        check("busy_strobe_value", output_value_o, last_val);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fix_parser.md
# fix_parser

Streaming FIX-protocol message parser: takes one ASCII byte per clock, splits the stream into tag=value fields delimited by SOH (0x01), and stores the fields of each complete message in an on-chip message store. A random-access lookup port returns the value of a requested tag within a selected stored message. It also reports a per-message checksum. The block sits between a byte-wide market-data ingress and downstream decision logic.

## Interface
- MAX_MSGS, 4: number of message slots in the store.
- MAX_FIELDS, 16: field slots per message.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  8  input byte, sampled every rising edge; there is no valid qualifier.
- find_tag_i  in  32  tag to look up, as ASCII right-aligned (e.g. "10" = 0x00003130, "9" = 0x00000039).
- message_num_i  in  10  index of the stored message to search.
- read_message_i  in  1  lookup request strobe.
- output_value_o  out  256  value found, as ASCII right-aligned, zero-filled.
- output_value_valid_o  out  1  one-cycle pulse; output_value_o is valid.
- start_of_header_o  out  1  one-cycle pulse at the start of each message.
- empty_o  out  1  no committed messages in the store.
- full_o  out  1  MAX_MSGS committed messages in the store.
- checksum_o  out  9  [7:0] computed checksum of the last message; [8] mismatch flag.

## Operation
- Parser states:
  - IDLE: discard bytes until an SOH, then go to TAG.
  - TAG: shift each non-'=' byte into a 32-bit tag register (shift left 8; the last 4 chars are kept).
    - '=' (0x3D) goes to VALUE.
    - SOH with an empty tag is ignored and the parser stays in TAG.
  - VALUE: shift bytes into a 256-bit value register (the last 32 bytes are kept).
    - SOH ends the field: write the field, clear the tag and value registers, and return to TAG.
- Field write:
  - The (tag, value) pair goes to slot [write message][field count].
  - Fields beyond MAX_FIELDS are dropped.
  - If full_o is set when the message starts, the entire message is dropped; parsing and checksum still run.
- Message start:
  - On completing the tag "8" (0x38) with no message open, pulse start_of_header_o and open a new message.
  - The field count resets to 0 and the checksum accumulator is cleared.
- Checksum:
  - Sum mod 256 of every byte from the '8' of the first tag through the SOH that precedes the tag "10".
  - The SOH before '8' is excluded.
- Message end: the field with tag 0x3130 ("10") terminated by SOH.
  - checksum_o[7:0] is set to the computed sum.
  - checksum_o[8] is set to 1 if the field value is not exactly three ASCII digits equal to the sum; otherwise 0.
  - The message is committed and the message count increments.
  - The parser closes the message and waits for the next tag "8".
- empty_o = (count == 0); full_o = (count == MAX_MSGS). Stored messages are never removed except by reset.
- Lookup:
  - In LK_IDLE, read_message_i=1 latches message_num_i and find_tag_i and starts the search. Strobes while a search is in progress are ignored.
  - If message_num_i >= count, the search ends immediately with no valid pulse.
  - Otherwise scan the field slots from 0 upward, one per cycle.
  - On the first tag match: drive output_value_o with the stored value, pulse output_value_valid_o, and return to LK_IDLE.
  - If no field matches, return to LK_IDLE with no pulse; output_value_o holds its previous value.
- A lookup and parsing run concurrently. A lookup sees only committed messages.

## Timing
- Reset values: output_value_o=0, output_value_valid_o=0, start_of_header_o=0, empty_o=1, full_o=0, checksum_o=0.
- Reset state: parser in IDLE, lookup in LK_IDLE, count=0.
- A reset mid-message discards the partial message.
- start_of_header_o rises on the clock after the '=' of tag "8" is sampled.
- Commit latency:
  - checksum_o and the count update one clock after the terminating SOH of the "10" field is sampled.
  - empty_o and full_o update on the same edge.
- Lookup latency:
  - The strobe is sampled at edge N.
  - A match at field k drives output_value_valid_o high for exactly one cycle after edge N+k+1.
  - Worst case: MAX_FIELDS+1 cycles.
- If the message committing at edge N is the one addressed by a strobe also sampled at edge N, it is not yet searchable.

## Test plan
- Reset, then stream "\x01 8=FIX.4.2\x01 9=178\x01 35=8\x01 49=PHLX\x01 52=20071123-05:30:00.000\x01 11=ATOMNOCCC9990900\x01 10=128\x01" (spaces for readability only) -> start_of_header_o pulses once; empty_o falls after the final SOH; checksum_o[7:0] equals the bench-computed mod-256 sum.
- Look up message 0, tag 0x3130 -> one valid pulse with output_value_o = 0x313238. Then tag 0x39 -> 0x313738. Then tag 0x3131 -> the 16 bytes "ATOMNOCCC9990900", right-aligned.
- Stream the same message with the "10" value bytes 0x87 0x65 0x45 -> checksum_o[8]=1. Look up message 1, tag 0x3130 -> 0x876545.
- Look up message 0, tag 0x3939, then message 5 with count 2 -> no valid pulse; output_value_o unchanged.
- Commit 5 messages with MAX_MSGS=4 -> full_o=1 after the 4th commit; the 5th is not stored, and a lookup of message 4 gives no pulse.
- Assert rst low in the middle of a message, then stream a full message -> the store holds only the new message as message 0.
- Issue a second strobe during an active search -> it is ignored and exactly one valid pulse results.
